// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier.
//   state_t        - FSM states of the multiplier sequencer
//   booth_digit_t  - decoded radix-4 digit {zero, neg, two}
//   iter_count()   - number of EXEC iterations for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit value = zero ? 0 : (neg ? -1 : +1) * (two ? 2 : 1)
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_digit_t;

  // Operands are extended by two bits, so WIDTH+2 multiplier bits are
  // retired two at a time.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: combinational radix-4 Booth recoder.
//   triplet  in  3  {b[1], b[0], guard} from the multiplier shift register
//   digit    out    decoded digit in {0, +-1, +-2}
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  always_comb begin
    digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
    case (triplet)
      3'b001, 3'b010: digit = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
      3'b011:         digit = '{zero: 1'b0, neg: 1'b0, two: 1'b1};
      3'b100:         digit = '{zero: 1'b0, neg: 1'b1, two: 1'b1};
      3'b101, 3'b110: digit = '{zero: 1'b0, neg: 1'b1, two: 1'b0};
      default:        digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// booth_r4_multiplier: sequential radix-4 Booth multiplier, two multiplier
// bits retired per clock, WIDTH/2+1 cycles per product.
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   multiplier    in   operand A (sampled at start)
//   multiplicand  in   operand B (sampled at start)
//   is_signed     in   1 = two's-complement operands (sampled at start)
//   op_start      in   level start request, honoured in IDLE only
//   op_clear      in   synchronous clear/abort, returns to IDLE
//   busy          out  operation in progress
//   op_done       out  result valid and held
//   result        out  2*WIDTH-bit product, zero outside DONE
module booth_r4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               is_signed,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N  = iter_count(WIDTH);
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam int AW = WIDTH + 4;  // accumulator: room for +-2M without overflow
  localparam int MW = WIDTH + 2;  // extended multiplier shift register

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] mcand;
  logic [MW-1:0]        mplr;
  logic                 guard;
  logic [CW-1:0]        cnt;

  booth_digit_t         digit;
  logic signed [AW-1:0] multiple;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_sh;
  logic [MW-1:0]        mplr_sh;
  logic                 last_iter;

  booth_r4_encoder u_enc (
    .triplet ({mplr[1:0], guard}),
    .digit   (digit)
  );

  // One Booth step: add digit*M to the upper accumulator, then shift the
  // combined {acc, mplr, guard} right by two with sign extension.
  always_comb begin
    multiple = '0;
    if (!digit.zero) multiple = digit.two ? (mcand <<< 1) : mcand;
    if (digit.neg) multiple = -multiple;
    sum       = acc + multiple;
    acc_sh    = sum >>> 2;
    mplr_sh   = {sum[1:0], mplr[MW-1:2]};
    last_iter = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (op_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (op_start) state_nxt = EXEC;
        EXEC:    if (last_iter) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      guard  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (op_clear) begin
      result <= '0;
    end else begin
      case (state)
        IDLE: if (op_start) begin
          mplr  <= {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
          mcand <= {{4{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
          acc   <= '0;
          guard <= 1'b0;
          cnt   <= '0;
        end
        EXEC: begin
          acc   <= acc_sh;
          mplr  <= mplr_sh;
          guard <= mplr[1];
          cnt   <= cnt + CW'(1);
          // After the final shift the product sits in {acc, mplr}.
          if (last_iter) result <= {acc_sh[WIDTH-3:0], mplr_sh};
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register, so no input-to-output path.
  assign busy    = (state == EXEC);
  assign op_done = (state == DONE);

endmodule

// File: tb/tb_booth_r4_multiplier.sv
module tb_booth_r4_multiplier;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 64-bit instance
  logic [63:0]  a64, b64;
  logic         sg64, start64, clr64, busy64, done64;
  logic [127:0] res64;

  // 8-bit instance
  logic [7:0]   a8, b8;
  logic         sg8, start8, clr8, busy8, done8;
  logic [15:0]  res8;

  // standalone encoder
  logic [2:0]   trip;
  booth_digit_t dig;

  booth_r4_multiplier #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .multiplier(a64), .multiplicand(b64),
    .is_signed(sg64), .op_start(start64), .op_clear(clr64),
    .busy(busy64), .op_done(done64), .result(res64)
  );

  booth_r4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .multiplier(a8), .multiplicand(b8),
    .is_signed(sg8), .op_start(start8), .op_clear(clr8),
    .busy(busy8), .op_done(done8), .result(res8)
  );

  booth_r4_encoder enc (.triplet(trip), .digit(dig));

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [15:0]  exp8_q[$];

  // {zero, neg, two} for triplets 000..111
  logic [2:0] enc_tab [8] = '{3'b100, 3'b000, 3'b000, 3'b001,
                              3'b011, 3'b010, 3'b010, 3'b100};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear64(input string tag);
    @(negedge clk); clr64 = 1'b1;
    @(posedge clk); #1;
    check({tag, " clr result"}, res64, 128'd0);
    check({tag, " clr done"}, {127'd0, done64}, 128'd0);
    check({tag, " clr busy"}, {127'd0, busy64}, 128'd0);
    @(negedge clk); clr64 = 1'b0;
  endtask

  task automatic wait_done64(output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (!done64 && cyc < 100) begin
      if (busy64) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic sg,
                       input logic hold, input string tag);
    logic [127:0] ea, eb, expv, got;
    int cyc, bcnt;
    ea = sg ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sg ? {{64{b[63]}}, b} : {64'd0, b};
    expv = ea * eb;
    @(negedge clk);
    a64 = a; b64 = b; sg64 = sg; start64 = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    // operand changes after the start edge must not matter
    a64 = ~a; b64 = b ^ 64'h5555_5555_5555_5555; sg64 = ~sg;
    if (!hold) start64 = 1'b0;
    wait_done64(cyc, bcnt);
    check({tag, " latency"}, 128'(cyc), 128'd33);
    check({tag, " busy cycles"}, 128'(bcnt), 128'd33);
    got = res64;
    if (exp_q.size() > 0) check({tag, " result"}, got, exp_q.pop_front());
    @(posedge clk); #1;
    check({tag, " held"}, res64, expv);
    check({tag, " done held"}, {127'd0, done64}, 128'd1);
    start64 = 1'b0;
    clear64(tag);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg, input string tag);
    logic [15:0] ea, eb;
    int cyc;
    ea = sg ? {{8{a[7]}}, a} : {8'd0, a};
    eb = sg ? {{8{b[7]}}, b} : {8'd0, b};
    @(negedge clk);
    a8 = a; b8 = b; sg8 = sg; start8 = 1'b1;
    exp8_q.push_back(ea * eb);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; sg8 = ~sg;
    cyc = 0;
    while (!done8 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'd5);
    if (exp8_q.size() > 0) check({tag, " result"}, {112'd0, res8}, {112'd0, exp8_q.pop_front()});
    @(negedge clk); clr8 = 1'b1;
    @(posedge clk); #1;
    check({tag, " clr result"}, {112'd0, res8}, 128'd0);
    @(negedge clk); clr8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcnt, seen;
    reset = 1'b1;
    a64 = '0; b64 = '0; sg64 = 1'b0; start64 = 1'b0; clr64 = 1'b0;
    a8 = '0; b8 = '0; sg8 = 1'b0; start8 = 1'b0; clr8 = 1'b0;
    trip = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy64", {127'd0, busy64}, 128'd0);
    check("reset done64", {127'd0, done64}, 128'd0);
    check("reset res64", res64, 128'd0);
    check("reset res8", {112'd0, res8}, 128'd0);
    @(negedge clk); reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      trip = 3'(t);
      #1;
      check($sformatf("encoder %0d", t), {125'd0, dig}, {125'd0, enc_tab[t]});
    end

    // signed small products, op_start held high through completion
    run64(64'd5, 64'd7, 1'b1, 1'b1, "s 5x7");
    run64(-64'sd5, 64'd7, 1'b1, 1'b0, "s -5x7");
    run64(64'd5, -64'sd7, 1'b1, 1'b0, "s 5x-7");
    run64(-64'sd5, -64'sd7, 1'b1, 1'b0, "s -5x-7");
    check("s -5x7 model", 128'(-128'sd35), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDD);

    // extremes
    run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, "s min*min");
    run64(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "s min*max");
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "u max*max");
    run64({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, "u rand");
    run64({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, "s rand");

    // 8-bit instance
    run8(8'd255, 8'd255, 1'b0, "w8 u 255x255");
    run8(8'd255, 8'd255, 1'b1, "w8 s -1x-1");
    run8(8'h80, 8'h80, 1'b1, "w8 s -128x-128");
    run8(8'h80, 8'h7F, 1'b1, "w8 s -128x127");

    // abort in EXEC with op_start held high; restart follows the clear
    @(negedge clk);
    a64 = 64'd9; b64 = 64'd11; sg64 = 1'b1; start64 = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done64 || res64 != 0) seen++;
    end
    check("abort no done", 128'(seen), 128'd0);
    @(negedge clk); clr64 = 1'b1;
    @(posedge clk); #1;
    check("abort busy", {127'd0, busy64}, 128'd0);
    check("abort result", res64, 128'd0);
    exp_q.push_back(128'd99);
    @(negedge clk); clr64 = 1'b0;
    @(posedge clk); #1;
    check("restart busy", {127'd0, busy64}, 128'd1);
    wait_done64(cyc, bcnt);
    check("restart latency", 128'(cyc), 128'd33);
    if (exp_q.size() > 0) check("restart result", res64, exp_q.pop_front());
    start64 = 1'b0;
    clear64("restart");

    // clear and start together in IDLE: no start
    @(negedge clk); clr64 = 1'b1; start64 = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy64 || done64) seen++;
    end
    check("clr+start no start", 128'(seen), 128'd0);
    @(negedge clk); clr64 = 1'b0; start64 = 1'b0;

    // asynchronous reset mid-EXEC (64) and in DONE (8)
    @(negedge clk);
    a64 = 64'd123; b64 = 64'd456; sg64 = 1'b0; start64 = 1'b1;
    a8 = 8'd3; b8 = 8'd5; sg8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(128'd56088);
    @(posedge clk); #1;
    start64 = 1'b0; start8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre-reset busy64", {127'd0, busy64}, 128'd1);
    check("pre-reset res8", {112'd0, res8}, 128'd15);
    #2 reset = 1'b1;
    #1;
    check("async busy64", {127'd0, busy64}, 128'd0);
    check("async done64", {127'd0, done64}, 128'd0);
    check("async res64", res64, 128'd0);
    check("async done8", {127'd0, done8}, 128'd0);
    check("async res8", {112'd0, res8}, 128'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    run64(64'd5, 64'd7, 1'b1, 1'b0, "post-reset 5x7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
